// File: rtl/demux_pkg.sv
// Shared definitions for the one-hot select demultiplexer.
//   NLANES          : number of output lanes
//   is_onehot8      : 1 when exactly one bit of an 8-bit select is set
//   onehot8_to_idx  : lane index of a one-hot select (meaningful only when
//                     the select is one-hot)
package demux_pkg;

  localparam int NLANES = 8;

  function automatic logic is_onehot8(input logic [7:0] s);
    // A power of two has no bits in common with itself minus one.
    return (s != 8'h00) && ((s & (s - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] onehot8_to_idx(input logic [7:0] s);
    logic [2:0] idx;
    idx = 3'd0;
    // OR-ing indices of set bits is exact for a one-hot input and avoids
    // a priority chain.
    for (int i = 0; i < 8; i++) begin
      if (s[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/demux8_lane.sv
// Single-entry output lane buffer.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   load     : write d into the lane this cycle (sets full)
//   d        : incoming data word
//   pop      : consumer takes the held word this cycle
//   q        : held data word (held after a pop; ignore while !full)
//   full     : lane holds a valid word
// A load in the same cycle as a pop refills the lane, so full stays high
// and a lane whose consumer is always ready sustains one word per cycle.
module demux8_lane #(
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [K-1:0] d,
  input  logic         pop,
  output logic [K-1:0] q,
  output logic         full
);

  logic [K-1:0] data_q, data_d;
  logic         full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/demux8_out.sv
// One-hot select demultiplexer with eight single-entry output lanes.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   a, a_valid      : input word and its valid
//   s               : one-hot lane select (bit i targets lane i)
//   a_ready         : combinational; high when the word would be taken
//   b0..b7, b_valid : lane data and lane-full flags
//   b_ready         : per-lane consumer ready
//   err, err_clr    : sticky bad-select flag and its clear
//   drop_cnt        : saturating count of dropped words
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready may depend on the other side's state but valid never
// waits for ready, and a lane holds data/valid stable until it is popped.
module demux8_out
  import demux_pkg::*;
#(
  parameter int k  = 1,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [k-1:0]  a,
  input  logic [7:0]    s,
  input  logic          a_valid,
  output logic          a_ready,
  output logic [k-1:0]  b0,
  output logic [k-1:0]  b1,
  output logic [k-1:0]  b2,
  output logic [k-1:0]  b3,
  output logic [k-1:0]  b4,
  output logic [k-1:0]  b5,
  output logic [k-1:0]  b6,
  output logic [k-1:0]  b7,
  output logic [7:0]    b_valid,
  input  logic [7:0]    b_ready,
  output logic          err,
  input  logic          err_clr,
  output logic [CW-1:0] drop_cnt
);

  logic          sel_ok;
  logic [2:0]    sel_idx;
  logic [7:0]    full;
  logic [7:0]    load;
  logic [7:0]    pop;
  logic          drop;
  logic [k-1:0]  lane_q [NLANES];

  logic          err_q, err_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Select decode and ready. A bad select is always "accepted" so the
  // producer never stalls on it; the word is then dropped.
  always_comb begin
    sel_ok  = is_onehot8(s);
    sel_idx = onehot8_to_idx(s);
    if (sel_ok) a_ready = !full[sel_idx] || b_ready[sel_idx];
    else        a_ready = 1'b1;
  end

  assign load = (a_valid && a_ready && sel_ok) ? s : 8'h00;
  assign pop  = full & b_ready;
  assign drop = a_valid && !sel_ok;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    demux8_lane #(.K(k)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (load[i]),
      .d    (a),
      .pop  (pop[i]),
      .q    (lane_q[i]),
      .full (full[i])
    );
  end

  // A drop in the same cycle as err_clr wins: the count restarts at one.
  always_comb begin
    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      err_d = 1'b1;
      if (err_clr)          drop_cnt_d = {{(CW-1){1'b0}}, 1'b1};
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (err_clr) begin
      err_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign b_valid  = full;
  assign err      = err_q;
  assign drop_cnt = drop_cnt_q;

  assign b0 = lane_q[0];
  assign b1 = lane_q[1];
  assign b2 = lane_q[2];
  assign b3 = lane_q[3];
  assign b4 = lane_q[4];
  assign b5 = lane_q[5];
  assign b6 = lane_q[6];
  assign b7 = lane_q[7];

endmodule

// File: doc/demux8_out.md
# demux8_out

One-hot select demultiplexer with per-lane output buffering: the distribution-side counterpart of the 8-input one-hot mux. A single `k`-bit input word, tagged with an 8-bit one-hot select, is routed into one of eight single-entry output lanes. Each lane has a valid/ready handshake. Invalid selects are dropped and counted. It sits between a single producer and up to eight consumers, for example per-unit writeback or per-port dispatch.

## Interface
Parameters:
- `k`, 1, data width of input and every output lane
- `CW`, 8, width of drop counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `a`  in  k  input data word
- `s`  in  8  one-hot lane select; bit i targets lane i
- `a_valid`  in  1  input word present
- `a_ready`  out  1  input word accepted this cycle when high with `a_valid`
- `b0`..`b7`  out  k each  lane data outputs
- `b_valid`  out  8  bit i: lane i holds a word
- `b_ready`  in  8  bit i: consumer i takes lane i word this cycle
- `err`  out  1  sticky flag: a non-one-hot select was received
- `err_clr`  in  1  clears `err` and `drop_cnt`
- `drop_cnt`  out  CW  saturating count of dropped words

## Operation
- Each lane i has a `full[i]` flag and a k-bit data register. `b_valid[i]` = `full[i]`, and `b<i>` = lane data register.
- `s` is valid when exactly one bit is set.
- `a_ready` is combinational:
  - for a valid `s` targeting lane i: `!full[i] | b_ready[i]`;
  - for an invalid `s` (zero or more than one bit set): 1.
- `a_ready` is driven per this rule regardless of `a_valid`.
- Accept (`a_valid & a_ready`, valid `s`, lane i): lane i data <= `a`, and `full[i]` <= 1.
- Pop (`full[i] & b_ready[i]`) without a same-cycle accept into lane i: `full[i]` <= 0. The data register holds its value; consumers must ignore it.
- Accept and pop on the same lane in the same cycle: lane is refilled with the new word, and `full[i]` stays 1. This gives full throughput with no bubble.
- Accept into lane i never disturbs lanes j != i. Any number of lanes may pop in the same cycle.
- Lane data and `b_valid[i]` are stable while `full[i]=1` and `b_ready[i]=0`.
- `b_ready[i]` while `full[i]=0` is ignored.
- Drop (`a_valid`, invalid `s`): the word is discarded, `err` <= 1, and `drop_cnt` increments, saturating at all-ones.
- `err_clr` clears `err` and `drop_cnt`. If a drop occurs in the same cycle as `err_clr`, the drop wins: `err`=1 and `drop_cnt`=1.

## Timing
- Reset values: `full`=0, so `b_valid`=8'h00; `b0`..`b7`=0; `err`=0; `drop_cnt`=0.
- While `rst`=1, `a_ready` still follows the combinational rule, but no accept, pop or drop takes effect. Reset has priority over all events, including a mid-transfer reset.
- Latency: a word accepted at edge N is visible on `b<i>` with `b_valid[i]`=1 immediately after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle into any single lane whose consumer holds `b_ready` high.
- Only `a_ready` has a combinational path, from `s` and `b_ready`. No input reaches `b*` combinationally. `err` and `drop_cnt` are registered.

## Structure
Shared package `demux_pkg`:
- constant `NLANES = 8`;
- function `is_onehot8(s)`;
- function `onehot8_to_idx(s)`, returning 3 bits.

Sub-module `demux8_lane`, instantiated 8x:
- ports: `clk`, `rst`, `load`, `d`, `pop`, `q`, `full`;
- implements the single-entry register with load-over-pop priority.

The top level contains select decode, `a_ready` generation and the drop/err logic.

## Test plan
- Reset, then idle: `b_valid`=8'h00, `err`=0, `drop_cnt`=0; with `s`=8'h04, `a_ready`=1.
- k=8: `a`=8'hA5, `s`=8'h08, `a_valid` for 1 cycle, `b_ready`=0 → next cycle `b_valid`=8'h08 and `b3`=8'hA5, held stable for 5 cycles. A second word to `s`=8'h08 sees `a_ready`=0. After `b_ready[3]`=1 for one cycle, `b_valid`=0.
- Streaming: `b_ready[5]`=1 continuously, 16 back-to-back words 0..15 with `s`=8'h20 → `a_ready`=1 every cycle, and `b5` shows 0..15 on consecutive cycles with `b_valid[5]`=1 throughout.
- Independence: fill lanes 0 and 7 and hold their ready low, then send to lane 2 → `a_ready`=1, `b_valid`=8'h85; lanes 0 and 7 data unchanged.
- Invalid selects: `s`=8'h00, then 8'h03, each with `a_valid` → `a_ready`=1, `b_valid` unchanged, `err`=1, `drop_cnt`=2. `err_clr` coinciding with a third drop → `err`=1, `drop_cnt`=1. 300 consecutive drops with CW=8 → `drop_cnt` saturates at 255.
- Reset mid-operation: lanes 1 and 6 full, `rst` asserted with a simultaneous accept to lane 4 → after the edge `b_valid`=8'h00 and `b0`..`b7`=0.
